// File: rtl/multicycle_alu.sv
// multicycle_alu: WIDTH-bit ALU with a registered result, a persistent
// {Z,C,N,O} flag register and a Start/Busy/Done handshake. Single-cycle ops
// complete at the accepting edge; multiply and divide iterate WIDTH times.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FunSel,
  input  logic             WF,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo, m;     // shared multiply/divide working registers
  logic [1:0]       op;            // op[1]: divide, op[0]: high half / remainder
  logic             wf_q;
  logic             iter_sel;
  logic             load_iter, write_single, write_iter;

  // single-cycle datapath results
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_o, s_zn;

  // iterative datapath results
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, i_res;

  assign iter_sel = FunSel[4] & (FunSel[3:2] == 2'b00);
  assign Busy     = (state == RUN);

  // State register.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and control strobes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned (which infers a latch).
    state_next   = state;
    load_iter    = 1'b0;
    write_single = 1'b0;
    write_iter   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (iter_sel) begin
            load_iter  = 1'b1;
            state_next = RUN;
          end else begin
            write_single = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          write_iter = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle operation result and flag candidates.
  always_comb begin
    s_res = '0;
    s_c   = FlagsOut[2];
    s_o   = FlagsOut[0];
    s_zn  = 1'b1;
    case (FunSel)
      5'b00000: s_res = A;
      5'b00001: s_res = B;
      5'b00010: s_res = ~A;
      5'b00011: s_res = ~B;
      5'b00100: begin
        {s_c, s_res} = {1'b0, A} + {1'b0, B};
        s_o = (A[WIDTH-1] == B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
      end
      5'b00101: begin
        {s_c, s_res} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, FlagsOut[2]};
        s_o = (A[WIDTH-1] == B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
      end
      5'b00110: begin
        {s_c, s_res} = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        s_o = (A[WIDTH-1] != B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
      end
      5'b00111: s_res = A & B;
      5'b01000: s_res = A | B;
      5'b01001: s_res = A ^ B;
      5'b01010: s_res = ~(A & B);
      5'b01011: begin s_res = {A[WIDTH-2:0], 1'b0};         s_c = A[WIDTH-1]; end
      5'b01100: begin s_res = {1'b0, A[WIDTH-1:1]};         s_c = A[0];       end
      5'b01101: begin s_res = {A[WIDTH-1], A[WIDTH-1:1]};   s_c = A[0];       end
      5'b01110: begin s_res = {A[WIDTH-2:0], FlagsOut[2]};  s_c = A[WIDTH-1]; end
      5'b01111: begin s_res = {FlagsOut[2], A[WIDTH-1:1]};  s_c = A[0];       end
      default:  s_zn = 1'b0;   // reserved codes: result 0, flags untouched
    endcase
  end

  // One shift-add multiply step or one restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m};
    div_ge    = ~div_diff[WIDTH];
    if (op[1]) begin
      nxt_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
    i_res = op[0] ? nxt_hi : nxt_lo;
  end

  // Datapath, result and flag registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      op       <= '0;
      wf_q     <= 1'b0;
      ALUOut   <= '0;
      FlagsOut <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= write_single | write_iter;
      if (load_iter) begin
        count <= CW'(WIDTH);
        op    <= FunSel[1:0];
        wf_q  <= WF;
        hi    <= '0;
        lo    <= FunSel[1] ? A : B;
        m     <= FunSel[1] ? B : A;
      end else if (state == RUN) begin
        count <= count - CW'(1);
        hi    <= nxt_hi;
        lo    <= nxt_lo;
      end
      if (write_single) begin
        ALUOut <= s_res;
        if (WF && s_zn)
          FlagsOut <= {s_res == '0, s_c, s_res[WIDTH-1], s_o};
      end
      if (write_iter) begin
        ALUOut <= i_res;
        if (wf_q)
          FlagsOut <= {i_res == '0, FlagsOut[2], i_res[WIDTH-1],
                       (op[1] && m == '0) ? 1'b1 : FlagsOut[0]};
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_multicycle_alu;

  localparam int WIDTH = 32;

  logic             Clock, Reset, Start, WF, Busy, Done;
  logic [WIDTH-1:0] A, B, ALUOut;
  logic [4:0]       FunSel;
  logic [3:0]       FlagsOut;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  mflags;
  logic [31:0] last_res;
  logic [3:0]  last_flags;

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .FunSel(FunSel), .WF(WF), .ALUOut(ALUOut), .FlagsOut(FlagsOut),
    .Busy(Busy), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: result and flag update from the operation rules.
  function automatic void model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic wf, inout logic [3:0] fl, output logic [31:0] r);
    logic [63:0] w, prod;
    logic c, o, rsv;
    c = fl[2]; o = fl[0]; rsv = 1'b0; r = '0;
    prod = {32'd0, a} * {32'd0, b};
    case (f)
      5'd0: r = a;
      5'd1: r = b;
      5'd2: r = ~a;
      5'd3: r = ~b;
      5'd4, 5'd5: begin
        w = {32'd0, a} + {32'd0, b} + ((f == 5'd5) ? {63'd0, c} : 64'd0);
        r = w[31:0]; c = w[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd6: begin
        r = a - b; c = (a >= b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd7:  r = a & b;
      5'd8:  r = a | b;
      5'd9:  r = a ^ b;
      5'd10: r = ~(a & b);
      5'd11: begin r = a << 1; c = a[31]; end
      5'd12: begin r = a >> 1; c = a[0]; end
      5'd13: begin r = $unsigned($signed(a) >>> 1); c = a[0]; end
      5'd14: begin r = {a[30:0], c}; c = a[31]; end
      5'd15: begin r = {c, a[31:1]}; c = a[0]; end
      5'd16: r = prod[31:0];
      5'd17: r = prod[63:32];
      5'd18: begin r = (b == 0) ? 32'hFFFFFFFF : a / b; if (b == 0) o = 1'b1; end
      5'd19: begin r = (b == 0) ? a : a % b;            if (b == 0) o = 1'b1; end
      default: rsv = 1'b1;
    endcase
    if (wf && !rsv) fl = {r == 0, c, r[31], o};
  endfunction

  // Issue one op, check handshake timing, result and flags.
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input logic wf);
    logic [31:0] er;
    logic        iter;
    int          cyc;
    model(f, a, b, wf, mflags, er);
    iter = (f >= 5'd16) && (f <= 5'd19);
    @(negedge Clock);
    A = a; B = b; FunSel = f; WF = wf; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    if (!iter) begin
      check("single_done", Done, 1);
      check("single_busy", Busy, 0);
    end else begin
      check("iter_busy", Busy, 1);
      check("iter_nodone", Done, 0);
      cyc = 0;
      while (!Done && cyc < 2 * WIDTH) begin
        // Scramble inputs and request another op; both must be ignored.
        @(negedge Clock);
        A = $urandom; B = $urandom; FunSel = 5'($urandom_range(0, 15)); WF = 1'($urandom);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        cyc++;
        if (!Done) check("busy_hold", Busy, 1);
      end
      check("iter_latency", cyc, WIDTH);
      check("busy_clear", Busy, 0);
    end
    check("result", ALUOut, er);
    check("flags", FlagsOut, mflags);
    last_res   = ALUOut;
    last_flags = FlagsOut;
  endtask

  initial begin
    logic        saw_done;
    logic [4:0]  f;
    logic [31:0] a, b;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; FunSel = '0; WF = 1'b0;
    mflags = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_out", ALUOut, 0);
    check("rst_flags", FlagsOut, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    @(negedge Clock) Reset = 1'b0;

    run_op(5'b00100, 32'h12341234, 32'h43214321, 1'b1);
    check("tp_add", last_res, 32'h55555555);
    check("tp_add_f", last_flags, 4'b0000);
    run_op(5'b00100, 32'hFFFFFFFF, 32'h1, 1'b1);
    check("tp_addc", last_res, 32'h0);
    check("tp_addc_f", last_flags, 4'b1100);
    run_op(5'b00101, 32'h77777777, 32'h88888888, 1'b1);
    check("tp_adc", last_res, 32'h0);
    check("tp_adc_f", last_flags, 4'b1100);
    run_op(5'b00110, 32'd5, 32'd7, 1'b0);
    check("tp_sub_nowf", last_res, 32'hFFFFFFFE);
    check("tp_sub_nowf_f", last_flags, 4'b1100);
    run_op(5'b00110, 32'd5, 32'd7, 1'b1);
    check("tp_sub_f", last_flags, 4'b0010);
    run_op(5'b10000, 32'h00010000, 32'h00010000, 1'b1);
    check("tp_mullo", last_res, 32'h0);
    check("tp_mullo_f", last_flags, 4'b1000);
    run_op(5'b10001, 32'h00010000, 32'h00010000, 1'b1);
    check("tp_mulhi", last_res, 32'h1);
    run_op(5'b10010, 32'd100, 32'd7, 1'b1);
    check("tp_divu", last_res, 32'd14);
    run_op(5'b10011, 32'd100, 32'd7, 1'b1);
    check("tp_remu", last_res, 32'd2);
    run_op(5'b10010, 32'd100, 32'd0, 1'b1);
    check("tp_div0", last_res, 32'hFFFFFFFF);
    check("tp_div0_f", last_flags, 4'b0011);
    run_op(5'b10011, 32'd100, 32'd0, 1'b1);
    check("tp_rem0", last_res, 32'd100);
    check("tp_rem0_f", last_flags, 4'b0001);

    // Reset in the middle of a multiply aborts it.
    @(negedge Clock);
    A = 32'h1234; B = 32'h5678; FunSel = 5'b10000; WF = 1'b1; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;
    check("abort_busy", Busy, 0);
    check("abort_out", ALUOut, 0);
    check("abort_flags", FlagsOut, 0);
    check("abort_done", Done, 0);
    @(negedge Clock) Reset = 1'b0;
    mflags = '0;
    saw_done = 1'b0;
    repeat (2 * WIDTH) begin
      @(posedge Clock); #1;
      if (Done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op(5'b00100, 32'd1, 32'd2, 1'b1);
    check("after_abort", last_res, 32'd3);

    // Randomized ops, biased towards iterative codes and zero divisors.
    repeat (150) begin
      f = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 19)) : 5'($urandom_range(0, 31));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF;
      run_op(f, a, b, 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
